updown_counter: RTL and testbench

//   Parametrised modulo up/down counter: the successor to the fixed 4-bit

---
 rtl/updown_counter.sv | 89 ++++++++
 tb/tb_updown_counter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter.sv
// Modulo up/down counter with prescaler, load, wrap/saturate, tc pulse, sticky ovf; optional snapshot via COUNTER_SNAPSHOT_EN.
// Latency: value/tc/ovf update on the tick edge (visible next cycle); no backpressure, a tick is never stalled.
module updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clr_ovf,
`ifdef COUNTER_SNAPSHOT_EN
  input  logic             snap,
  output logic [WIDTH-1:0] snap_value,
  output logic             snap_valid,
`endif
  output logic [WIDTH-1:0] value,
  output logic             tc,
  output logic             ovf
);

  localparam int             PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PS_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0] MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [PW-1:0]    prescaler, prescaler_nxt;
  logic [WIDTH-1:0] value_nxt;
  logic             tc_nxt, ovf_nxt, tick, at_bound;

  always_comb begin
    tick          = en && (prescaler == PS_LAST);
    at_bound      = up ? (value == TOP) : (value == '0);
    prescaler_nxt = prescaler;
    value_nxt     = value;
    tc_nxt        = 1'b0;
    ovf_nxt       = clr_ovf ? 1'b0 : ovf;
    if (load) begin
      // Load wins over a coincident tick; out-of-range values clamp to the top.
      prescaler_nxt = '0;
      value_nxt     = ({1'b0, load_value} >= MOD_EXT) ? TOP : load_value;
    end else begin
      if (en)
        prescaler_nxt = (prescaler == PS_LAST) ? '0 : prescaler + 1'b1;
      if (tick) begin
        if (at_bound) begin
          tc_nxt  = 1'b1;
          ovf_nxt = 1'b1;
          if (SATURATE == 0)
            value_nxt = up ? '0 : TOP;
        end else begin
          value_nxt = up ? value + 1'b1 : value - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      value     <= '0;
      tc        <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      prescaler <= prescaler_nxt;
      value     <= value_nxt;
      tc        <= tc_nxt;
      ovf       <= ovf_nxt;
    end
  end

`ifdef COUNTER_SNAPSHOT_EN
  // Captures the pre-update count, so a snap alongside a load sees the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_value <= '0;
      snap_valid <= 1'b0;
    end else if (snap) begin
      snap_value <= value;
      snap_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_updown_counter.sv
// Self-checking bench: three counter configurations share one stimulus stream; a scoreboard queue holds expected outputs.
module tb_updown_counter;

  logic       clk = 1'b0;
  logic       reset, en, up, load, clr_ovf, snap;
  logic [3:0] load_value;

  logic [3:0] va, vb, vc;
  logic       tca, tcb, tcc, ova, ovb, ovc;
`ifdef COUNTER_SNAPSHOT_EN
  logic [3:0] sva, svb, svc;
  logic       sla, slb, slc;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // dut 0: plain wrap, dut 1: prescale by 3, dut 2: saturating
  updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) dut_a (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_value(load_value),
    .clr_ovf(clr_ovf),
`ifdef COUNTER_SNAPSHOT_EN
    .snap(snap), .snap_value(sva), .snap_valid(sla),
`endif
    .value(va), .tc(tca), .ovf(ova));

  updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .SATURATE(0)) dut_b (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_value(load_value),
    .clr_ovf(clr_ovf),
`ifdef COUNTER_SNAPSHOT_EN
    .snap(snap), .snap_value(svb), .snap_valid(slb),
`endif
    .value(vb), .tc(tcb), .ovf(ovb));

  updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) dut_c (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_value(load_value),
    .clr_ovf(clr_ovf),
`ifdef COUNTER_SNAPSHOT_EN
    .snap(snap), .snap_value(svc), .snap_valid(slc),
`endif
    .value(vc), .tc(tcc), .ovf(ovc));

  typedef struct {
    int         dut;
    logic [3:0] value;
    logic       tc;
    logic       ovf;
  } exp_t;
  exp_t sbq[$];

  int m_val[3], m_ps[3];
  bit m_tc[3], m_ovf[3];
  int m_snapv;
  bit m_snapl;
  int P_PS[3]  = '{1, 3, 1};
  bit P_SAT[3] = '{0, 0, 1};
  localparam int MOD = 10;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input int i, input bit r, e, u, l, input int lv, input bit c);
    bit tick, bnd;
    if (r) begin
      m_val[i] = 0; m_ps[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
    end else if (l) begin
      m_val[i] = (lv > MOD - 1) ? MOD - 1 : lv;
      m_ps[i]  = 0;
      m_tc[i]  = 0;
      if (c) m_ovf[i] = 0;
    end else begin
      tick = e && (m_ps[i] == P_PS[i] - 1);
      if (e) m_ps[i] = (m_ps[i] + 1) % P_PS[i];
      bnd = tick && (u ? (m_val[i] == MOD - 1) : (m_val[i] == 0));
      if (tick && !bnd) m_val[i] = u ? m_val[i] + 1 : m_val[i] - 1;
      if (bnd && !P_SAT[i]) m_val[i] = u ? 0 : MOD - 1;
      m_tc[i] = bnd;
      if (bnd) m_ovf[i] = 1;
      else if (c) m_ovf[i] = 0;
    end
  endtask

  task automatic step(input bit r, e, u, l, input int lv, input bit c, input bit s);
    exp_t x;
    reset = r; en = e; up = u; load = l; load_value = lv[3:0]; clr_ovf = c; snap = s;
    if (r) begin m_snapv = 0; m_snapl = 0; end
    else if (s) begin m_snapv = m_val[0]; m_snapl = 1; end
    for (int i = 0; i < 3; i++) begin
      model(i, r, e, u, l, lv, c);
      sbq.push_back('{i, m_val[i][3:0], m_tc[i], m_ovf[i]});
    end
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      x = sbq.pop_front();
      case (x.dut)
        0: begin check("a_value", va, x.value); check("a_tc", tca, x.tc); check("a_ovf", ova, x.ovf); end
        1: begin check("b_value", vb, x.value); check("b_tc", tcb, x.tc); check("b_ovf", ovb, x.ovf); end
        default: begin check("c_value", vc, x.value); check("c_tc", tcc, x.tc); check("c_ovf", ovc, x.ovf); end
      endcase
    end
`ifdef COUNTER_SNAPSHOT_EN
    check("snap_value", sva, m_snapv);
    check("snap_valid", sla, m_snapl);
`endif
  endtask

  task automatic tick_n(input int n, input bit u);
    for (int k = 0; k < n; k++) step(0, 1, u, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; en = 0; up = 1; load = 0; load_value = 0; clr_ovf = 0; snap = 0;
    // reset state
    step(1, 0, 1, 0, 0, 0, 0);
    check("rst_value", va, 0); check("rst_tc", tca, 0); check("rst_ovf", ova, 0);

    // count up through the wrap
    tick_n(9, 1);
    check("up9_value", va, 9); check("up9_tc", tca, 0);
    tick_n(1, 1);
    check("wrap_value", va, 0); check("wrap_tc", tca, 1); check("wrap_ovf", ova, 1);
    tick_n(2, 1);
    check("post_wrap_tc", tca, 0); check("post_wrap_ovf", ova, 1);

    // load 3 and count down through 0
    step(0, 1, 0, 1, 3, 0, 0);
    check("load3", va, 3);
    tick_n(4, 0);
    check("down_tc", tca, 1); check("down_wrap", va, 9);
    tick_n(1, 0);
    check("down8", va, 8); check("down8_tc", tca, 0);
    step(0, 0, 0, 1, 12, 0, 0);
    check("clamp", va, 9);
    step(0, 0, 1, 0, 0, 1, 0);
    check("clr_ovf", ova, 0);

    // prescale by 3, with an en gap mid-period
    step(1, 0, 1, 0, 0, 0, 0);
    tick_n(4, 1);
    check("ps_after4", vb, 1);
    for (int k = 0; k < 4; k++) step(0, 0, 1, 0, 0, 0, 0);
    check("ps_hold", vb, 1);
    tick_n(1, 1);
    check("ps_phase", vb, 1);
    tick_n(1, 1);
    check("ps_tick", vb, 2);
    step(1, 0, 1, 0, 0, 0, 0);
    tick_n(9, 1);
    check("ps_nine", vb, 3);

    // saturate at top; clr_ovf loses to a boundary tick
    step(0, 0, 1, 1, 8, 1, 0);
    tick_n(1, 1);
    check("sat9", vc, 9); check("sat9_tc", tcc, 0);
    tick_n(2, 1);
    check("sat_hold", vc, 9); check("sat_tc", tcc, 1);
    step(0, 1, 1, 0, 0, 1, 0);
    check("sat_set_wins", ovc, 1); check("sat_tc3", tcc, 1);
    step(0, 0, 0, 1, 0, 0, 0);
    tick_n(2, 0);
    check("sat_low", vc, 0); check("sat_low_tc", tcc, 1);

    // reset mid-count beats load and en
    step(1, 0, 1, 0, 0, 0, 0);
    tick_n(6, 1);
    check("pre_rst", va, 6);
    step(1, 1, 1, 1, 5, 0, 1);
    check("rst_mid_value", va, 0); check("rst_mid_tc", tca, 0); check("rst_mid_ovf", ova, 0);
    tick_n(2, 1);
    check("resume", va, 2);

    // snapshot (also snap+load capturing pre-load value)
    step(1, 0, 1, 0, 0, 0, 0);
    tick_n(4, 1);
    step(0, 1, 1, 0, 0, 0, 1);
    check("snap_cont", va, 5);
`ifdef COUNTER_SNAPSHOT_EN
    check("snap4", sva, 4); check("snap4_valid", sla, 1);
`endif
    step(0, 1, 1, 1, 2, 0, 1);
`ifdef COUNTER_SNAPSHOT_EN
    check("snap_preload", sva, 5);
`endif
    check("load2", va, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no end expected end");
    $fatal(1, "timeout");
  end

endmodule
